tick_rate_selector: RTL and testbench



---
 rtl/tick_rate_selector.sv | 109 ++++++++++
 tb/tb_tick_rate_selector.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/tick_rate_selector.sv
// Programmable-rate divided clock: a base prescaler feeds a half-period counter whose
// length is picked by prioritised mode requests. Rate changes land only on full-period boundaries.
module tick_rate_selector #(
    parameter int N_RATES    = 4,
    parameter int PRESCALE   = 50000,
    parameter int RATE_SHIFT = 1,
    parameter int N_REQ      = 4,
    localparam int SW        = (N_RATES > 1) ? $clog2(N_RATES) : 1,
    parameter logic [SW*N_REQ-1:0] RATE_MAP = {SW'(3), SW'(1), SW'(0), SW'(1)},
    parameter int DEFAULT_RATE = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             hold,
    output logic             new_clock,
    output logic             tick,
    output logic [SW-1:0]    rate_sel,
    output logic             switching
);

    localparam int HW = (N_RATES - 1) * RATE_SHIFT + 1;
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [SW-1:0] MAX_RATE = SW'(N_RATES - 1);
    localparam logic [SW-1:0] DEF_RATE =
        (SW'(DEFAULT_RATE) > MAX_RATE) ? MAX_RATE : SW'(DEFAULT_RATE);
    localparam logic [CW-1:0] BASE_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] base_cnt_reg, base_cnt_next;
    logic [HW-1:0] half_cnt_reg, half_cnt_next;
    logic          new_clock_reg, new_clock_next;
    logic          tick_reg, tick_next;
    logic [SW-1:0] rate_sel_reg, rate_sel_next;
    logic          switching_reg, switching_next;

    logic [SW-1:0] map_entry [N_REQ];
    logic [SW-1:0] target;
    logic [HW-1:0] half_last;
    logic          base_tick;

    // Out-of-range map entries saturate to the slowest rate.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_map
        assign map_entry[gi] = (RATE_MAP[gi*SW +: SW] > MAX_RATE) ? MAX_RATE
                                                                  : RATE_MAP[gi*SW +: SW];
    end

    // Later (higher-index) requests overwrite earlier ones, giving top-index priority.
    always_comb begin
        target = DEF_RATE;
        for (int j = 0; j < N_REQ; j++) begin
            if (req[j]) begin
                target = map_entry[j];
            end
        end
    end

    assign base_tick = (base_cnt_reg == BASE_LAST);
    assign half_last = (HW'(1) << (int'(rate_sel_reg) * RATE_SHIFT)) - HW'(1);

    always_comb begin
        base_cnt_next  = base_cnt_reg;
        half_cnt_next  = half_cnt_reg;
        new_clock_next = new_clock_reg;
        tick_next      = 1'b0;
        rate_sel_next  = rate_sel_reg;
        switching_next = switching_reg;
        if (!hold) begin
            base_cnt_next = base_tick ? '0 : base_cnt_reg + CW'(1);
            if (base_tick) begin
                if (half_cnt_reg == half_last) begin
                    half_cnt_next  = '0;
                    new_clock_next = !new_clock_reg;
                    tick_next      = !new_clock_reg;
                    // A falling edge closes a full period: the only safe point to retune.
                    if (new_clock_reg) begin
                        rate_sel_next = target;
                    end
                end else begin
                    half_cnt_next = half_cnt_reg + HW'(1);
                end
            end
            switching_next = (target != rate_sel_next);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_cnt_reg  <= '0;
            half_cnt_reg  <= '0;
            new_clock_reg <= 1'b0;
            tick_reg      <= 1'b0;
            rate_sel_reg  <= DEF_RATE;
            switching_reg <= 1'b0;
        end else begin
            base_cnt_reg  <= base_cnt_next;
            half_cnt_reg  <= half_cnt_next;
            new_clock_reg <= new_clock_next;
            tick_reg      <= tick_next;
            rate_sel_reg  <= rate_sel_next;
            switching_reg <= switching_next;
        end
    end

    assign new_clock = new_clock_reg;
    assign tick      = tick_reg;
    assign rate_sel  = rate_sel_reg;
    assign switching = switching_reg;

endmodule

// File: tb/tb_tick_rate_selector.sv
// Directed bench for tick_rate_selector at PRESCALE=2; every cycle's expected state
// is written out as phases of hand-derived length.
module tb_tick_rate_selector;

    logic       clock;
    logic       reset_n;
    logic [3:0] req;
    logic       hold;
    logic       new_clock;
    logic       tick;
    logic [1:0] rate_sel;
    logic       switching;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    tick_rate_selector #(
        .N_RATES   (4),
        .PRESCALE  (2),
        .RATE_SHIFT(1),
        .N_REQ     (4)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .hold     (hold),
        .new_clock(new_clock),
        .tick     (tick),
        .rate_sel (rate_sel),
        .switching(switching)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic nc, input logic tk,
                               input logic sw, input logic [1:0] rs);
        check_eq({tag, " new_clock"}, 32'(new_clock), 32'(nc));
        check_eq({tag, " tick"},      32'(tick),      32'(tk));
        check_eq({tag, " switching"}, 32'(switching), 32'(sw));
        check_eq({tag, " rate_sel"},  32'(rate_sel),  32'(rs));
    endtask

    // len cycles with new_clock at lvl; tick expected only on the first cycle if first_tick.
    task automatic ph(input int len, input logic lvl, input logic first_tick,
                      input logic sw, input logic [1:0] rs);
        for (int i = 0; i < len; i++) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
            check_state($sformatf("c%0d", cyc), lvl, first_tick && (i == 0), sw, rs);
            $display("cycle %0d: new_clock=%0b tick=%0b switching=%0b rate_sel=%0d",
                     cyc, new_clock, tick, switching, rate_sel);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        hold    = 1'b0;
        #2;
        check_state("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Rate 0: period 4, first rise two clocks after release.
        ph(1, 1'b0, 1'b0, 1'b0, 2'd0);
        ph(2, 1'b1, 1'b1, 1'b0, 2'd0);
        ph(2, 1'b0, 1'b0, 1'b0, 2'd0);
        ph(2, 1'b1, 1'b1, 1'b0, 2'd0);
        ph(2, 1'b0, 1'b0, 1'b0, 2'd0);
        ph(1, 1'b1, 1'b1, 1'b0, 2'd0);

        // Request rate 1 during the high phase; switch lands on the fall.
        req = 4'b0001;
        ph(1, 1'b1, 1'b0, 1'b1, 2'd0);
        ph(4, 1'b0, 1'b0, 1'b0, 2'd1);
        ph(4, 1'b1, 1'b1, 1'b0, 2'd1);
        ph(1, 1'b0, 1'b0, 1'b0, 2'd1);

        // req3 outranks req1: map entry 3 -> rate 3, period 32.
        req = 4'b1010;
        ph(3, 1'b0, 1'b0, 1'b1, 2'd1);
        ph(4, 1'b1, 1'b1, 1'b1, 2'd1);
        ph(16, 1'b0, 1'b0, 1'b0, 2'd3);
        ph(16, 1'b1, 1'b1, 1'b0, 2'd3);
        ph(16, 1'b0, 1'b0, 1'b0, 2'd3);
        ph(1, 1'b1, 1'b1, 1'b0, 2'd3);

        // Back to default rate 0 at the next fall.
        req = 4'b0000;
        ph(15, 1'b1, 1'b0, 1'b1, 2'd3);
        ph(2, 1'b0, 1'b0, 1'b0, 2'd0);
        ph(1, 1'b1, 1'b1, 1'b0, 2'd0);

        // One-cycle request that is withdrawn before the boundary.
        req = 4'b0001;
        ph(1, 1'b1, 1'b0, 1'b1, 2'd0);
        req = 4'b0000;
        ph(2, 1'b0, 1'b0, 1'b0, 2'd0);
        ph(2, 1'b1, 1'b1, 1'b0, 2'd0);
        ph(2, 1'b0, 1'b0, 1'b0, 2'd0);
        ph(1, 1'b1, 1'b1, 1'b0, 2'd0);

        // Hold for 10 cycles in the high phase with a pending request.
        hold = 1'b1;
        req  = 4'b0001;
        ph(10, 1'b1, 1'b0, 1'b0, 2'd0);
        hold = 1'b0;
        ph(1, 1'b1, 1'b0, 1'b1, 2'd0);
        ph(4, 1'b0, 1'b0, 1'b0, 2'd1);
        ph(1, 1'b1, 1'b1, 1'b0, 2'd1);

        // Move to rate 3, then reset in the middle of its high phase.
        req = 4'b1000;
        ph(3, 1'b1, 1'b0, 1'b1, 2'd1);
        ph(16, 1'b0, 1'b0, 1'b0, 2'd3);
        ph(3, 1'b1, 1'b1, 1'b0, 2'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check_state("async_reset", 1'b0, 1'b0, 1'b0, 2'd0);
        req = 4'b0000;
        @(negedge clock);
        reset_n = 1'b1;
        ph(1, 1'b0, 1'b0, 1'b0, 2'd0);
        ph(2, 1'b1, 1'b1, 1'b0, 2'd0);
        ph(1, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
